// File: rtl/rf_multiport.sv
// Multi-port register file: one write port, NUM_RD synchronous read ports,
// optional hardwired-zero entry 0 and write-to-read bypass, post-reset clear.
module rf_multiport #(
    parameter  int DATA_W   = 32,
    parameter  int DEPTH    = 32,
    parameter  int NUM_RD   = 2,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wen,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD-1:0]        ren,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rvalid,
    output logic                     ready
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_write_live;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;
    logic [DATA_W-1:0] w_rd_val [NUM_RD];

    // The clear sequencer shares the single write port, so storage needs no reset.
    always_comb begin
        w_write_live = (r_state == ST_RUN) && wen && !((ZERO_REG != 0) && (waddr == '0));
        w_mem_we     = (r_state == ST_CLEAR) || w_write_live;
        w_mem_addr   = (r_state == ST_CLEAR) ? r_clr_ptr : waddr;
        w_mem_data   = (r_state == ST_CLEAR) ? '0 : wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst && w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    always_comb begin
        w_rd_val = '{default: '0};
        for (int i = 0; i < NUM_RD; i++) begin
            if ((ZERO_REG != 0) && (raddr[i*ADDR_W +: ADDR_W] == '0)) begin
                w_rd_val[i] = '0;
            end else if ((BYPASS != 0) && w_write_live && (waddr == raddr[i*ADDR_W +: ADDR_W])) begin
                w_rd_val[i] = wdata;
            end else begin
                w_rd_val[i] = r_mem[raddr[i*ADDR_W +: ADDR_W]];
            end
        end
    end

    // Ready rises on the same edge that clears the last entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
            rdata     <= '0;
            rvalid    <= '0;
            ready     <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    rvalid    <= '0;
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    if (r_clr_ptr == ADDR_W'(DEPTH - 1)) begin
                        r_state <= ST_RUN;
                        ready   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < NUM_RD; i++) begin
                        rvalid[i] <= ren[i];
                        if (ren[i]) begin
                            rdata[i*DATA_W +: DATA_W] <= w_rd_val[i];
                        end
                    end
                end
                default: begin
                    r_state   <= ST_CLEAR;
                    r_clr_ptr <= '0;
                end
            endcase
        end
    end

endmodule
